ps2_rx_checked: RTL

Parametrised PS/2 receive front end that succeeds the basic single-byte receiver. It synchronises and deglitches ps2c/ps2d and checks each 11-bit frame for start, odd parity and stop. It aborts stalled frames with a watchdog and buffers good bytes in a small FIFO behind a valid/ready handshake. It sits between the PS/2 pins and the keyboard scan-code decoder feeding the pong paddle logic.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_rx_fifo.sv | 45 ++++
 rtl/ps2_rx_checked.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive front end: FSM encoding, frame size
// and the odd-parity helper used by the frame checker.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Bits shifted after the start bit: 8 data, parity, stop.
  localparam int FRAME_DATA_BITS = 10;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return (^data) ^ parity;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous byte FIFO; extra pointer bit distinguishes full from empty.
module ps2_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_rx_checked.sv
// PS/2 receiver with deglitch filter, start/parity/stop checking, in-frame
// watchdog and a byte FIFO behind a valid/ready handshake.
module ps2_rx_checked
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       parity_err_tick,
  output logic       frame_err_tick,
  output logic       timeout_tick,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int         WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT = 4'(FRAME_DATA_BITS - 1);

  logic                  ps2c_p0, ps2c_p1;
  logic                  ps2d_p0, ps2d_p1;
  logic [FILTER_LEN-1:0] filt;
  logic                  f_val, f_val_next;
  logic                  neg_edge;

  state_t                state, state_next;
  logic [3:0]            bit_cnt, bit_cnt_next;
  logic [WD_W-1:0]       wd, wd_next, wd_inc;
  logic [FRAME_DATA_BITS-1:0] sh;
  logic                  shift_en;
  logic                  par_ok;
  logic                  push;
  logic                  fifo_empty, fifo_full;
  logic                  ovf_set;

  // Stage p0/p1: two-flop synchronisers, then the ps2c deglitch shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2c_p0 <= 1'b1;
      ps2c_p1 <= 1'b1;
      ps2d_p0 <= 1'b1;
      ps2d_p1 <= 1'b1;
      filt    <= '1;
      f_val   <= 1'b1;
    end else begin
      ps2c_p0 <= ps2c;
      ps2c_p1 <= ps2c_p0;
      ps2d_p0 <= ps2d;
      ps2d_p1 <= ps2d_p0;
      filt    <= {filt[FILTER_LEN-2:0], ps2c_p1};
      f_val   <= f_val_next;
    end
  end

  always_comb begin
    f_val_next = f_val;
    if (&filt)       f_val_next = 1'b1;
    else if (~|filt) f_val_next = 1'b0;
  end

  assign neg_edge = f_val & ~f_val_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      wd      <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      wd      <= wd_next;
    end
  end

  // Frame contents are pure data; they are only consumed after a full frame.
  always_ff @(posedge clk) begin
    if (shift_en) sh <= {ps2d_p1, sh[FRAME_DATA_BITS-1:1]};
  end

  assign wd_inc = wd + WD_W'(1);
  assign par_ok = odd_parity_ok(sh[7:0], sh[8]);

  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    wd_next         = wd;
    shift_en        = 1'b0;
    push            = 1'b0;
    parity_err_tick = 1'b0;
    frame_err_tick  = 1'b0;
    timeout_tick    = 1'b0;
    case (state)
      IDLE: begin
        wd_next = '0;
        if (neg_edge && rx_en && !ps2d_p1) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (neg_edge) begin
          shift_en     = 1'b1;
          wd_next      = '0;
          bit_cnt_next = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) state_next = CHECK;
        end else if (wd_inc == WD_LAST) begin
          timeout_tick = 1'b1;
          wd_next      = '0;
          state_next   = IDLE;
        end else begin
          wd_next = wd_inc;
        end
      end
      CHECK: begin
        push            = par_ok && sh[9];
        parity_err_tick = !par_ok;
        frame_err_tick  = !sh[9];
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (rx_ready),
    .din     (sh[7:0]),
    .dout    (rx_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign rx_valid = !fifo_empty;
  assign ovf_set  = push && fifo_full && !(rx_ready && !fifo_empty);

  // Clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (clr_ovf) overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
  end

endmodule
